// File: rtl/uart_pkg.sv
// Shared UART definitions: receive/transmit FSM states and parity helper.
package uart_pkg;

    localparam int MAX_DATA_BITS = 9;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK
    } uart_state_e;

    // Parity bit that makes the frame's ones count even (odd=0) or odd (odd=1).
    function automatic logic parity_bit(
        input logic [MAX_DATA_BITS-1:0] data,
        input logic                     odd
    );
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receive FIFO read port: first-word fall-through with valid/ready.
interface uart_rx_fifo_if #(
    parameter int DATA_BITS = 8
);

    logic [DATA_BITS-1:0] rd_data;
    logic                 rd_valid;
    logic                 rd_ready;

    modport master (
        output rd_data,
        output rd_valid,
        input  rd_ready
    );

    modport slave (
        input  rd_data,
        input  rd_valid,
        output rd_ready
    );

endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock circular FIFO with occupancy counter; shared by RX and TX.
module uart_sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A pop frees the head slot this cycle, so a push into a full FIFO may proceed.
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rptr];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= push_data;
                wptr      <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver: synchroniser, mid-bit sampling FSM, parity/stop checks,
// and a receive FIFO with sticky error flags.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int DEPTH        = 16
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     RX_data,
    uart_rx_fifo_if.master           rd,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     rx_busy,
    output logic                     parity_err,
    output logic                     frame_err,
    output logic                     overrun_err,
    input  logic                     err_clr
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);

    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

    logic [1:0]           sync;
    logic                 rx_s;
    uart_state_e          state;
    logic [CW-1:0]        cnt;
    logic [IW-1:0]        idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bad;
    logic                 push;
    logic                 mid;
    logic                 full;
    logic                 empty;
    logic                 expect_par;

    // Resetting to idle-high keeps a low line during reset from faking a start.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], RX_data};
        end
    end

    assign rx_s       = sync[1];
    assign mid        = (cnt == BIT_LAST);
    assign rx_busy    = (state != IDLE);
    assign expect_par = parity_bit(MAX_DATA_BITS'(shreg), PARITY_ODD != 0);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            shreg      <= '0;
            par_bad    <= 1'b0;
            push       <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            push <= 1'b0;
            if (err_clr) begin
                parity_err <= 1'b0;
                frame_err  <= 1'b0;
            end
            unique case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        idx     <= '0;
                        par_bad <= 1'b0;
                        state   <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (mid) begin
                        cnt   <= '0;
                        shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                        idx   <= idx + 1'b1;
                        if (idx == IDX_LAST) begin
                            state <= (PARITY_EN != 0) ? PARITY : STOP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PARITY: begin
                    if (mid) begin
                        cnt   <= '0;
                        state <= STOP;
                        if (rx_s != expect_par) begin
                            par_bad    <= 1'b1;
                            parity_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (mid) begin
                        cnt <= '0;
                        if (rx_s) begin
                            push  <= ~par_bad;
                            state <= IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            overrun_err <= 1'b0;
        end else if (push & full & ~rd.rd_ready) begin
            overrun_err <= 1'b1;
        end else if (err_clr) begin
            overrun_err <= 1'b0;
        end
    end

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .push      (push),
        .push_data (shreg),
        .pop       (rd.rd_ready),
        .head      (rd.rd_data),
        .full      (full),
        .empty     (empty),
        .count     (fifo_count)
    );

    assign rd.rd_valid = ~empty;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: three configurations against a queue-based model.
module tb_uart_rx_fifo;

    localparam int CPB = 16;

    logic CLK;
    logic RST_N;
    logic rx   [3];
    logic clr  [3];
    logic busy [3];
    logic pe   [3];
    logic fe   [3];
    logic oe   [3];
    logic [4:0] cnt_a;
    logic [4:0] cnt_p;
    logic [2:0] cnt_d;

    uart_rx_fifo_if #(.DATA_BITS(8)) if_a ();
    uart_rx_fifo_if #(.DATA_BITS(8)) if_p ();
    uart_rx_fifo_if #(.DATA_BITS(8)) if_d ();

    uart_rx_fifo dut_a (
        .CLK(CLK), .RST_N(RST_N), .RX_data(rx[0]), .rd(if_a.master),
        .fifo_count(cnt_a), .rx_busy(busy[0]), .parity_err(pe[0]),
        .frame_err(fe[0]), .overrun_err(oe[0]), .err_clr(clr[0])
    );

    uart_rx_fifo #(.PARITY_EN(1), .PARITY_ODD(0)) dut_p (
        .CLK(CLK), .RST_N(RST_N), .RX_data(rx[1]), .rd(if_p.master),
        .fifo_count(cnt_p), .rx_busy(busy[1]), .parity_err(pe[1]),
        .frame_err(fe[1]), .overrun_err(oe[1]), .err_clr(clr[1])
    );

    uart_rx_fifo #(.DEPTH(4)) dut_d (
        .CLK(CLK), .RST_N(RST_N), .RX_data(rx[2]), .rd(if_d.master),
        .fifo_count(cnt_d), .rx_busy(busy[2]), .parity_err(pe[2]),
        .frame_err(fe[2]), .overrun_err(oe[2]), .err_clr(clr[2])
    );

    logic [31:0] o_data [3];
    logic [31:0] o_cnt  [3];
    logic        o_valid[3];

    assign o_data[0]  = 32'(if_a.rd_data);
    assign o_data[1]  = 32'(if_p.rd_data);
    assign o_data[2]  = 32'(if_d.rd_data);
    assign o_cnt[0]   = 32'(cnt_a);
    assign o_cnt[1]   = 32'(cnt_p);
    assign o_cnt[2]   = 32'(cnt_d);
    assign o_valid[0] = if_a.rd_valid;
    assign o_valid[1] = if_p.rd_valid;
    assign o_valid[2] = if_d.rd_valid;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: one queue of expected bytes and flag set per DUT.
    int   q0[$];
    int   q1[$];
    int   q2[$];
    int   dep [3];
    logic e_pe[3];
    logic e_fe[3];
    logic e_oe[3];
    int   n_cmp;
    int   n_bad;
    int   lat;

    function automatic int qsize(input int id);
        case (id)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic int qhead(input int id);
        case (id)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction

    task automatic qpush(input int id, input int v);
        if (qsize(id) >= dep[id]) begin
            e_oe[id] = 1'b1;
        end else begin
            case (id)
                0:       q0.push_back(v);
                1:       q1.push_back(v);
                default: q2.push_back(v);
            endcase
        end
    endtask

    task automatic qpop(input int id);
        if (qsize(id) != 0) begin
            case (id)
                0:       q0.delete(0);
                1:       q1.delete(0);
                default: q2.delete(0);
            endcase
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        q2.delete();
        for (int i = 0; i < 3; i++) begin
            e_pe[i] = 1'b0;
            e_fe[i] = 1'b0;
            e_oe[i] = 1'b0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_state(input int id, input string tag);
        chk({tag, ".valid"}, 32'(o_valid[id]), 32'(qsize(id) != 0));
        chk({tag, ".count"}, o_cnt[id], 32'(qsize(id)));
        if (qsize(id) != 0) chk({tag, ".data"}, o_data[id], 32'(qhead(id)));
        chk({tag, ".busy"}, 32'(busy[id]), 32'(0));
        chk({tag, ".perr"}, 32'(pe[id]), 32'(e_pe[id]));
        chk({tag, ".ferr"}, 32'(fe[id]), 32'(e_fe[id]));
        chk({tag, ".oerr"}, 32'(oe[id]), 32'(e_oe[id]));
    endtask

    task automatic set_ready(input int id, input logic v);
        case (id)
            0:       if_a.rd_ready = v;
            1:       if_p.rd_ready = v;
            default: if_d.rd_ready = v;
        endcase
    endtask

    task automatic pop_chk(input int id, input string tag);
        chk({tag, ".valid"}, 32'(o_valid[id]), 32'(qsize(id) != 0));
        if (qsize(id) != 0) chk({tag, ".data"}, o_data[id], 32'(qhead(id)));
        set_ready(id, 1'b1);
        @(negedge CLK);
        set_ready(id, 1'b0);
        qpop(id);
    endtask

    task automatic drain(input int id);
        while (qsize(id) != 0) pop_chk(id, "drain");
    endtask

    task automatic clear_err(input int id);
        clr[id] = 1'b1;
        @(negedge CLK);
        clr[id] = 1'b0;
        e_pe[id] = 1'b0;
        e_fe[id] = 1'b0;
        e_oe[id] = 1'b0;
    endtask

    // Line waveform only; the parity DUT (id 1) gets an even-parity bit.
    task automatic drive_frame(input int id, input logic [7:0] d,
                               input logic pbad, input logic sbad);
        logic [10:0] bits;
        int          n;
        bits      = '0;
        bits[8:1] = d;
        n         = 9;
        if (id == 1) begin
            bits[9] = (^d) ^ pbad;
            n       = 10;
        end
        bits[n] = ~sbad;
        n++;
        for (int i = 0; i < n; i++) begin
            rx[id] = bits[i];
            repeat (CPB) @(negedge CLK);
        end
    endtask

    task automatic send_frame(input int id, input logic [7:0] d,
                              input logic pbad, input logic sbad);
        logic par_wrong;
        drive_frame(id, d, pbad, sbad);
        par_wrong = (id == 1) && pbad;
        if (par_wrong) e_pe[id] = 1'b1;
        if (sbad) e_fe[id] = 1'b1;
        else if (!par_wrong) qpush(id, 32'(d));
    endtask

    task automatic recover(input int id);
        repeat (40) @(negedge CLK);
        rx[id] = 1'b1;
        repeat (CPB) @(negedge CLK);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

    initial begin
        RST_N = 1'b0;
        dep[0] = 16;
        dep[1] = 16;
        dep[2] = 4;
        for (int i = 0; i < 3; i++) begin
            rx[i]  = 1'b1;
            clr[i] = 1'b0;
        end
        if_a.rd_ready = 1'b0;
        if_p.rd_ready = 1'b0;
        if_d.rd_ready = 1'b0;
        n_cmp = 0;
        n_bad = 0;
        model_reset();

        repeat (3) @(negedge CLK);
        for (int i = 0; i < 3; i++) chk_state(i, "reset");
        chk("reset.data", o_data[0], 32'(0));
        RST_N = 1'b1;
        repeat (4) @(negedge CLK);

        lat = 0;
        fork
            send_frame(0, 8'hA5, 1'b0, 1'b0);
            begin
                while (o_valid[0] !== 1'b1 && lat < 400) begin
                    @(negedge CLK);
                    lat++;
                end
            end
        join
        chk("a5.latency_ok", 32'(lat >= 150 && lat <= 160), 32'(1));
        chk_state(0, "a5");
        pop_chk(0, "a5.pop");

        rx[0] = 1'b0;
        repeat (4) @(negedge CLK);
        rx[0] = 1'b1;
        chk("false_start.busy", 32'(busy[0]), 32'(1));
        repeat (20) @(negedge CLK);
        chk_state(0, "false_start");

        send_frame(0, 8'h3C, 1'b0, 1'b1);
        recover(0);
        chk_state(0, "break");
        send_frame(0, 8'h81, 1'b0, 1'b0);
        chk_state(0, "after_break");
        clear_err(0);
        chk_state(0, "ferr_clr");
        drain(0);

        send_frame(1, 8'h07, 1'b1, 1'b0);
        chk_state(1, "par_bad");
        send_frame(1, 8'h07, 1'b0, 1'b0);
        chk_state(1, "par_good");
        clear_err(1);
        chk_state(1, "perr_clr");
        drain(1);

        for (int v = 1; v <= 5; v++) send_frame(2, 8'(v), 1'b0, 1'b0);
        chk_state(2, "overrun");
        drain(2);
        chk_state(2, "overrun.empty");
        clear_err(2);
        chk_state(2, "oerr_clr");

        for (int k = 0; k < 15; k++) begin
            int         id;
            logic [7:0] d;
            logic       pb;
            logic       sb;
            id = $urandom_range(0, 2);
            d  = 8'($urandom);
            pb = (id == 1) && ($urandom_range(0, 3) == 0);
            sb = ($urandom_range(0, 7) == 0);
            send_frame(id, d, pb, sb);
            if (sb) recover(id);
            chk_state(id, "rnd");
            if ($urandom_range(0, 1) == 1) pop_chk(id, "rnd.pop");
        end

        drain(0);
        send_frame(0, 8'h11, 1'b0, 1'b0);
        send_frame(0, 8'h22, 1'b0, 1'b0);
        chk_state(0, "pre_reset");
        fork
            drive_frame(0, 8'hFF, 1'b0, 1'b0);
            begin
                repeat (60) @(negedge CLK);
                RST_N = 1'b0;
                @(negedge CLK);
                chk("mid_reset.valid", 32'(o_valid[0]), 32'(0));
                chk("mid_reset.count", o_cnt[0], 32'(0));
                chk("mid_reset.data", o_data[0], 32'(0));
                chk("mid_reset.busy", 32'(busy[0]), 32'(0));
                repeat (3) @(negedge CLK);
                RST_N = 1'b1;
            end
        join
        model_reset();
        repeat (5) @(negedge CLK);
        for (int i = 0; i < 3; i++) chk_state(i, "post_reset");
        send_frame(0, 8'h5A, 1'b0, 1'b0);
        chk_state(0, "after_reset_5a");
        pop_chk(0, "after_reset.pop");
        chk_state(0, "final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Parametrised serial receiver for the serial/JTAG-driver path; next generation of the single-clock 1-8-1 receiver.
- Adds a 2-flop input synchroniser, clock-count bit timing with mid-bit sampling, and false-start rejection.
- Adds configurable data width and optional parity, plus a proper circular receive FIFO with a valid/ready read port and sticky error flags.
- Sits between the RX pin and the UART controller's CPU-side register interface.

Parameters:
- CLKS_PER_BIT, 16, CLK cycles per bit; must be >= 4.
- DATA_BITS, 8, payload bits per frame, 5..9.
- PARITY_EN, 0, 1 = one parity bit between data and stop.
- PARITY_ODD, 0, 1 = odd parity, 0 = even; ignored when PARITY_EN=0.
- DEPTH, 16, FIFO entries; power of 2, >= 2.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- RX_data  in  1  asynchronous serial line; idle high.
- rd_data  out  DATA_BITS  FIFO head, first-word fall-through.
- rd_valid  out  1  FIFO not empty.
- rd_ready  in  1  pop when rd_valid & rd_ready.
- fifo_count  out  $clog2(DEPTH)+1  entries held.
- rx_busy  out  1  FSM not IDLE.
- parity_err  out  1  sticky parity error.
- frame_err  out  1  sticky stop-bit error.
- overrun_err  out  1  sticky; a good frame was dropped because the FIFO was full.
- err_clr  in  1  clears all three sticky flags.

Behaviour:
- Reset: all outputs 0. Synchroniser flops reset to 1 (idle). FSM = IDLE, FIFO pointers 0. rd_data is 0 after reset; after that it shows the head entry and is don't-care while empty.
- Synchroniser: rx_s is RX_data delayed by 2 CLK. All decisions use rx_s.
- Bit order: LSB first.
- FSM states:
  - IDLE: rx_s==0 -> START, cnt=0.
  - START: at cnt==CLKS_PER_BIT/2-1, sample rx_s.
    - 1: false start, go to IDLE with no flag.
    - 0: cnt=0, bit index=0 -> DATA.
  - DATA: sample at cnt==CLKS_PER_BIT-1, i.e. mid-bit. Shift the bit into the MSB of the shift register, shifting right. After DATA_BITS samples -> PARITY if PARITY_EN, else STOP.
  - PARITY: sample mid-bit. Error if XOR(data, parity bit) != PARITY_ODD.
  - STOP: sample mid-bit.
    - 1: frame good unless a parity error occurred. Go to IDLE, so a back-to-back start edge is caught within the second half of the stop bit.
    - 0: set frame_err and go to BREAK.
  - BREAK: wait for rx_s==1, then IDLE.
- Frame disposition:
  - A frame with a parity or framing error is discarded and never pushed.
  - A good frame raises a push request in the cycle after the stop sample.
  - Latency: rd_valid rises 1 CLK after that push cycle, when the FIFO was empty.
- FIFO:
  - Circular buffer with wrap-around pointers of $clog2(DEPTH) bits; fifo_count is the registered occupancy.
  - Push when not full: write and advance the write pointer.
  - Push when full without a pop: data dropped, overrun_err set, contents unchanged.
  - Push and pop in the same cycle: both occur, count unchanged. This includes the full case, so no overrun.
  - Pop when empty: ignored.
- Sticky flags: err_clr clears all three. If a set event and err_clr coincide, the set wins.
- Reset asserted mid-frame aborts the frame immediately and empties the FIFO. The line must read idle before the next start is detected; this holds naturally via the synchroniser reset value.

Decomposition:
- Shared package uart_pkg: FSM state enum (IDLE, START, DATA, PARITY, STOP, BREAK) and a parity helper function. The same enum and helper are reused by the future UART_TX.
- One natural sub-module: uart_sync_fifo, parametrised on WIDTH and DEPTH, with push, pop, full, empty and count. It is reusable by the TX path.
- The receive FSM, bit counter and synchroniser live in the top module.

Test Plan:
- Defaults, frame 0xA5 with 1 stop bit. Required: exactly one push; rd_data=0xA5, rd_valid=1, fifo_count=1 about 9.5×16+3 CLK after the start edge. No error flags.
- RX low for 4 CLK then high. Required: FSM returns to IDLE, no push, no flags, rx_busy deasserts.
- Frame 0x3C with stop bit driven 0, line held low 40 CLK, then idle, then a good 0x81. Required: frame_err=1, only 0x81 in the FIFO. Then err_clr pulse: frame_err=0.
- PARITY_EN=1, PARITY_ODD=0; frame 0x07 with parity bit 0, which is wrong. Required: parity_err=1, no push. Then 0x07 with parity 1: pushed, rd_data=0x07.
- DEPTH=4; send 5 good frames 0x01..0x05 with rd_ready=0. Required: fifo_count=4, overrun_err=1. Pops return 0x01..0x04, then rd_valid=0.
- Pull RST_N low mid-DATA with 2 FIFO entries held, then release. Required: all outputs 0 and fifo_count=0; the next frame 0x5A is received correctly.
